// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_tx and the future uart_rx.
// Contents:
//   DefaultWidth      - default data bits per frame
//   DefaultClksPerBit - default clk cycles per bit (50 MHz / 115200)
//   tx_state_t        - transmitter FSM state encoding
package uart_pkg;

  localparam int unsigned DefaultWidth      = 8;
  localparam int unsigned DefaultClksPerBit = 434;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StData,
    StStop
  } tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Read-side handshake between an upstream fifo and the UART transmitter.
// Signals:
//   fifo_empty   - fifo empty flag (fifo -> uart)
//   fifo_rd_en   - one-cycle pop strobe (uart -> fifo)
//   fifo_rd_data - registered read data, valid the cycle after fifo_rd_en (fifo -> uart)
// Modports: master = uart_tx side, slave = fifo side.
interface uart_tx_if #(
  parameter int unsigned WIDTH = uart_pkg::DefaultWidth
) ();

  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Baud-rate counter shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 and wraps; tick is high on the wrap cycle.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears the count
//   clear - synchronous clear, holds the count at zero and suppresses tick
//   tick  - high in the last cycle of each bit period
module uart_baud_cnt import uart_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LastCnt) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from an upstream fifo and serialises them as
// 8N1-style frames (start bit, WIDTH data bits LSB first, one stop bit).
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset, aborts any frame in progress
//   fifo - uart_tx_if master: fifo_empty / fifo_rd_en / fifo_rd_data
//   tx   - registered serial line, idle high
//   busy - high whenever the FSM is not idle (combinational from state)
module uart_tx import uart_pkg::*; #(
  parameter int unsigned WIDTH        = DefaultWidth,
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.master fifo,
  output logic     tx,
  output logic     busy
);

  if (CLKS_PER_BIT < 2) begin : g_clks_per_bit_check
    $fatal(1, "uart_tx: CLKS_PER_BIT must be >= 2");
  end

  localparam int unsigned BitCntW = $clog2(WIDTH) + 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(WIDTH - 1);

  tx_state_t           state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic                tx_q, tx_d;
  logic                rd_en;
  logic                baud_clear;
  logic                baud_tick;

  // Baud counter is held at zero until the start bit, so START begins on count 0.
  assign baud_clear = (state_q == StIdle) || (state_q == StFetch) || (state_q == StLoad);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rd_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo.fifo_empty) state_d = StFetch;
      end
      StFetch: begin
        rd_en   = 1'b1;
        state_d = StLoad;
      end
      StLoad: begin
        shift_d   = fifo.fifo_rd_data;
        bit_cnt_d = '0;
        state_d   = StStart;
      end
      StStart: begin
        if (baud_tick) state_d = StData;
      end
      StData: begin
        if (baud_tick) begin
          if (bit_cnt_q == LastBit) begin
            state_d = StStop;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (baud_tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // tx is computed from the next state so the registered line changes on the
  // same edge as the state, e.g. the start bit appears the first cycle of START.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  assign fifo.fifo_rd_en = rd_en;
  assign tx              = tx_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (WIDTH=8, CLKS_PER_BIT=4) fed by a
// behavioural 4-deep fifo with registered read data.
module tb_uart_tx;

  localparam int unsigned W        = 8;
  localparam int unsigned C        = 4;
  localparam int          CI       = 4;
  localparam int          FrameLen = (W + 2) * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic busy;

  uart_tx_if #(.WIDTH(W)) ifc ();

  uart_tx #(
    .WIDTH       (W),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fifo(ifc),
    .tx  (tx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Upstream fifo model, depth 4.
  logic [W-1:0] mem [4];
  logic [1:0]   f_wr      = '0;
  logic [1:0]   f_rd      = '0;
  logic [2:0]   f_cnt     = '0;
  logic         push      = 1'b0;
  logic [W-1:0] push_data = '0;
  logic [W-1:0] rd_data_q = '0;
  logic         do_pop;
  logic         do_push;

  assign do_pop            = ifc.fifo_rd_en && (f_cnt != 3'd0);
  assign do_push           = push && ((f_cnt != 3'd4) || do_pop);
  assign ifc.fifo_empty    = (f_cnt == 3'd0);
  assign ifc.fifo_rd_data  = rd_data_q;

  always @(posedge clk) begin
    if (do_pop) begin
      rd_data_q <= mem[f_rd];
      f_rd      <= f_rd + 2'd1;
    end
    if (do_push) begin
      mem[f_wr] <= push_data;
      f_wr      <= f_wr + 2'd1;
    end
    f_cnt <= f_cnt + {2'b00, do_push} - {2'b00, do_pop};
  end

  int rd_pulses = 0;
  always @(posedge clk) begin
    if (ifc.fifo_rd_en === 1'b1) rd_pulses <= rd_pulses + 1;
  end

  // Push driver: one byte per cycle from push_q while the fifo has room.
  logic [W-1:0] push_q [$];
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (push_q.size() != 0 && f_cnt < 3'd4) begin
        push      = 1'b1;
        push_data = push_q.pop_front();
      end else begin
        push = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for every cycle of one frame, from the framing rules.
  function automatic logic [FrameLen-1:0] frame_wave(input logic [W-1:0] b);
    logic [FrameLen-1:0] w;
    for (int i = 0; i < FrameLen; i++) begin
      int k;
      k = i / CI;
      if (k == 0) w[i] = 1'b0;
      else if (k == int'(W) + 1) w[i] = 1'b1;
      else w[i] = b[k-1];
    end
    return w;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_start(output bit ok, output int gap);
    ok  = 1'b0;
    gap = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx === 1'b0) begin
        ok = 1'b1;
        return;
      end
      gap++;
    end
  endtask

  // Captures one frame (the current sample is bit 0 when already=1) and
  // compares it with the next byte expected by the scoreboard.
  task automatic check_frame(input string tag, input bit already, output int gap);
    bit                  ok;
    logic [FrameLen-1:0] w;
    logic [W-1:0]        b;
    logic                lb;
    gap = 0;
    ok  = already;
    if (!already) begin
      wait_start(ok, gap);
      chk({tag, "_start"}, 64'(ok), 64'd1);
    end
    if (ok) begin
      w[0] = tx;
      for (int i = 1; i < FrameLen; i++) begin
        tick();
        w[i] = tx;
      end
      lb = busy;
      b  = exp_q.pop_front();
      chk(tag, 64'(w), 64'(frame_wave(b)));
      chk({tag, "_busy_in_stop"}, 64'(lb), 64'd1);
    end
  endtask

  initial begin
    int           gap;
    int           rd0;
    int           viol;
    bit           ok;
    logic [W-1:0] r;
    logic [W-1:0] v;
    logic [4:0]   rd_hist;
    logic [4:0]   tx_hist;

    // Reset state and reset overriding a non-empty fifo.
    tick();
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_en", 64'(ifc.fifo_rd_en), 64'd0);
    r = W'($urandom);
    push_q.push_back(r);
    exp_q.push_back(r);
    repeat (6) tick();
    chk("rst_fifo_nonempty", 64'(ifc.fifo_empty), 64'd0);
    chk("rst_override_rd", 64'(rd_pulses), 64'd0);
    chk("rst_override_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    check_frame("after_rst", 1'b0, gap);

    // Idle hold.
    rd0  = rd_pulses;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || ifc.fifo_rd_en !== 1'b0) viol++;
    end
    chk("idle_hold_viol", 64'(viol), 64'd0);
    chk("idle_hold_rd", 64'(rd_pulses - rd0), 64'd0);

    // Latency from push into an empty fifo.
    r = W'($urandom);
    push_q.push_back(r);
    exp_q.push_back(r);
    for (int i = 1; i <= 5; i++) begin
      tick();
      rd_hist[i-1] = ifc.fifo_rd_en;
      tx_hist[i-1] = tx;
    end
    chk("lat_rd_en_n1", 64'(rd_hist[1]), 64'd0);
    chk("lat_rd_en_n2", 64'(rd_hist[2]), 64'd1);
    chk("lat_rd_en_n3", 64'(rd_hist[3]), 64'd0);
    chk("lat_tx_n3", 64'(tx_hist[3]), 64'd1);
    chk("lat_tx_n4", 64'(tx_hist[4]), 64'd0);
    if (tx_hist[4] === 1'b0) check_frame("lat_frame", 1'b1, gap);
    else check_frame("lat_frame", 1'b0, gap);

    // Single byte 0xA5.
    rd0 = rd_pulses;
    push_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    check_frame("a5_frame", 1'b0, gap);
    tick();
    chk("a5_busy_after", 64'(busy), 64'd0);
    chk("a5_tx_after", 64'(tx), 64'd1);
    chk("a5_rd_pulses", 64'(rd_pulses - rd0), 64'd1);

    // Back-to-back 0x00, 0xFF.
    rd0 = rd_pulses;
    push_q.push_back(8'h00);
    push_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    check_frame("b2b_00", 1'b0, gap);
    check_frame("b2b_ff", 1'b0, gap);
    chk("b2b_gap", 64'(gap), 64'd3);
    tick();
    chk("b2b_rd_pulses", 64'(rd_pulses - rd0), 64'd2);
    chk("b2b_empty", 64'(ifc.fifo_empty), 64'd1);

    // Reset during data bit 3 of 0x3C; the partial byte is dropped.
    v = 8'h3C;
    push_q.push_back(v);
    wait_start(ok, gap);
    chk("midrst_start", 64'(ok), 64'd1);
    repeat (17) tick();
    chk("midrst_bit3", 64'(tx), 64'(v[3]));
    rst = 1'b1;
    tick();
    chk("midrst_tx", 64'(tx), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst  = 1'b0;
    rd0  = rd_pulses;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    chk("midrst_quiet", 64'(viol), 64'd0);
    chk("midrst_no_pop", 64'(rd_pulses - rd0), 64'd0);
    r = W'($urandom);
    push_q.push_back(r);
    exp_q.push_back(r);
    check_frame("midrst_next", 1'b0, gap);

    // Fill the fifo with 4 bytes while the first frame is on the line.
    rd0 = rd_pulses;
    for (int i = 0; i < 5; i++) exp_q.push_back(W'($urandom));
    push_q.push_back(exp_q[0]);
    wait_start(ok, gap);
    chk("fill_start", 64'(ok), 64'd1);
    for (int i = 1; i < 5; i++) push_q.push_back(exp_q[i]);
    if (ok) check_frame("fill_0", 1'b1, gap);
    for (int i = 1; i < 5; i++) begin
      check_frame($sformatf("fill_%0d", i), 1'b0, gap);
      chk($sformatf("fill_gap_%0d", i), 64'(gap), 64'd3);
    end
    chk("fill_rd_pulses", 64'(rd_pulses - rd0), 64'd5);

    // Random burst larger than the fifo.
    rd0 = rd_pulses;
    for (int i = 0; i < 8; i++) begin
      r = W'($urandom);
      push_q.push_back(r);
      exp_q.push_back(r);
    end
    for (int i = 0; i < 8; i++) begin
      check_frame($sformatf("burst_%0d", i), 1'b0, gap);
      if (i != 0) chk($sformatf("burst_gap_%0d", i), 64'(gap), 64'd3);
    end
    tick();
    chk("burst_rd_pulses", 64'(rd_pulses - rd0), 64'd8);
    chk("burst_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per frame; must equal the upstream fifo WIDTH.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (50 MHz / 115200); legal range >= 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port fifo_empty  input  1  upstream fifo empty flag.
REQ-006 SHALL have port fifo_rd_en  output  1  one-cycle pop strobe to the upstream fifo.
REQ-007 SHALL have port fifo_rd_data  input  WIDTH  upstream fifo registered read data, valid the cycle after fifo_rd_en.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement the states IDLE, FETCH, LOAD, START, DATA and STOP.
REQ-011 SHALL move from IDLE to FETCH on the first edge where fifo_empty=0; with fifo_empty=1 it SHALL remain in IDLE with tx=1.
REQ-012 SHALL assert fifo_rd_en only in FETCH, for exactly one cycle per frame; fifo_rd_en SHALL never be high in any other state.
REQ-013 SHALL in LOAD capture fifo_rd_data into a WIDTH-bit shift register, clear the bit counter and the baud counter, then go to START.
REQ-014 SHALL drive tx=0 for exactly CLKS_PER_BIT cycles in START, then go to DATA.
REQ-015 SHALL in DATA shift out WIDTH bits LSB first, each held for exactly CLKS_PER_BIT cycles; after bit WIDTH-1 it SHALL go to STOP.
REQ-016 SHALL drive tx=1 for exactly CLKS_PER_BIT cycles in STOP, then return to IDLE.
REQ-017 SHALL use a baud counter that counts 0..CLKS_PER_BIT-1 and wraps to 0, with the state or bit advancing on the wrap cycle.
REQ-018 SHALL size the baud counter at $clog2(CLKS_PER_BIT) bits and the bit counter at $clog2(WIDTH)+1 bits; no counter SHALL overflow.
REQ-019 SHALL meet this latency: with fifo_empty=0 sampled in IDLE at cycle n, fifo_rd_en=1 in cycle n+1, and the start bit (tx=0) begins in cycle n+3.
REQ-020 SHALL leave a 3-cycle inter-frame gap for back-to-back frames: IDLE, FETCH and LOAD, all with tx=1, between the end of STOP and the next start bit.
REQ-021 SHALL ignore fifo_empty outside IDLE; a fifo that becomes empty or refills mid-frame SHALL NOT alter the frame in progress.
REQ-022 SHALL register tx, giving a glitch-free output; busy SHALL be combinational from the state.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, force state=IDLE, tx=1, fifo_rd_en=0, busy=0, and clear both counters and the shift register.
REQ-024 SHALL, if rst asserts mid-frame, abort the frame: tx returns to 1 the cycle after the reset edge and no byte is popped; the partial byte is lost.
REQ-025 SHALL treat reset as overriding all other inputs in the same cycle, including fifo_empty=0.

Structure
REQ-026 SHALL define the state enum type (tx_state_t) and the default constants for WIDTH and CLKS_PER_BIT in a shared package uart_pkg, which the future uart_rx will also use.
REQ-027 SHALL implement the baud counter as one sub-module, uart_baud_cnt, with inputs clk, rst and clear and output tick, for reuse by uart_rx.
REQ-028 SHALL have an elaboration-time check that fails if CLKS_PER_BIT < 2.

Verification (bench: WIDTH=8, CLKS_PER_BIT=4, driven by the real fifo with DEPTH=4)
REQ-029 SHALL cover single byte: push 0xA5 -> fifo_rd_en pulses once; tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles (40 cycles total); busy falls after the stop bit.
REQ-030 SHALL cover back-to-back: push 0x00 and 0xFF together -> two frames separated by exactly 3 idle-high cycles; exactly two fifo_rd_en pulses; fifo_empty=1 at the end.
REQ-031 SHALL cover idle hold: fifo_empty=1 for 100 cycles -> tx=1, busy=0 and fifo_rd_en=0 throughout.
REQ-032 SHALL cover reset mid-frame: assert rst during data bit 3 of 0x3C -> tx=1 and busy=0 the cycle after; no further fifo_rd_en until fifo_empty=0 is seen after rst deasserts.
REQ-033 SHALL cover fifo fill during a frame: push 4 bytes while the first is transmitting -> all 4 bytes are serialised in push order with no loss and no duplication.
REQ-034 SHALL cover latency: push at cycle n with the fifo empty -> fifo_rd_en at n+2 (the fifo's empty flag lags one cycle), and the start bit at n+4.
